// File: rtl/apb_pkg.sv
// Shared types for the APB4 master: FSM state encoding, strobe-width helper
// and the held response record.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

  localparam int unsigned MAX_DATA_W = 32;

  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the one that reaches TIMEOUT.
// TIMEOUT of 0 disables expiry entirely.
module apb_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;

  // Saturates at TIMEOUT so a long stall can never wrap back to a small count.
  always_ff @(posedge PCLK) begin
    if (PRESET || clear) begin
      cnt_q <= '0;
    end else if (tick && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the stalled cycle whose increment brings the count to TIMEOUT.
  assign expired = (TIMEOUT != 0) && tick && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb4_master_ctrl.sv
// APB4 master: converts valid/ready commands into SETUP/ACCESS transfers and
// returns each result on a held response channel, with a stall watchdog.
module apb4_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned STRB_W = strb_w(DATA_W)
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic [STRB_W-1:0] PSTRB,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  apb_state_e        state_q;
  logic              cmd_ready_q, rsp_valid_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  apb_rsp_t          rsp_q;
  logic              wd_expired;

  apb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clear  (state_q == SETUP),
    .tick   ((state_q == ACCESS) && !PREADY),
    .expired(wd_expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pstrb_q     <= cmd_write ? cmd_strb : '0;
            // Reads leave PWDATA at its last value to avoid needless toggling.
            if (cmd_write) pwdata_q <= cmd_wdata;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_q.rdata   <= pwrite_q ? '0 : MAX_DATA_W'(PRDATA);
            rsp_q.err     <= PSLVERR;
            rsp_q.timeout <= 1'b0;
            state_q       <= RESP;
          end else if (wd_expired) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb4_master_ctrl.sv
// Directed bench for apb4_master_ctrl: a small APB slave model with
// programmable wait states and error response, checked against hand values.
module tb_apb4_master_ctrl;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;

  int n_chk = 0;
  int n_err = 0;

  apb4_master_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Issues one command and plays the slave until rsp_valid or the cycle budget runs out.
  // lat counts cycles from the accepting edge to rsp_valid being visible.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                          input logic slverr, output int lat, output int acc,
                          output int psel_cyc, output logic stable, output logic [3:0] strb_obs);
    check_eq("cmd_ready_before_issue", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    PREADY    = 1'b0;
    PSLVERR   = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat = 1; acc = 0; psel_cyc = 0; stable = 1'b1; strb_obs = PSTRB;
    while (!rsp_valid && lat < 40) begin
      if (PSEL) begin
        psel_cyc++;
        if (PADDR !== addr || PWRITE !== wr || PSTRB !== strb_obs) stable = 1'b0;
      end
      if (PSEL && PENABLE) begin
        acc++;
        PREADY  = (acc > waits);
        PRDATA  = rdata;
        // Error asserted on stalled cycles too; only the completing one may count.
        PSLVERR = PREADY ? slverr : 1'b1;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
      end
      step();
      lat++;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    check_eq("rsp_within_budget", rsp_valid, 1'b1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("rsp_dropped_after_ready", rsp_valid, 1'b0);
    check_eq("cmd_ready_after_resp", cmd_ready, 1'b1);
  endtask

  int         lat, acc, psel_cyc;
  logic       stable;
  logic [3:0] strb_obs;

  initial begin
    #100000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    step(); step();
    check_eq("reset_cmd_ready", cmd_ready, 1'b0);
    check_eq("reset_psel", PSEL, 1'b0);
    check_eq("reset_rsp_valid", rsp_valid, 1'b0);
    check_eq("reset_paddr", PADDR, 32'h0);
    PRESET = 1'b0;
    step();
    check_eq("idle_cmd_ready", cmd_ready, 1'b1);

    // Zero-wait write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001;
    cmd_strb = 4'hF;
    step();
    cmd_valid = 1'b0;
    check_eq("wr_setup_psel", {PSEL, PENABLE}, 2'b10);
    check_eq("wr_setup_cmd_ready", cmd_ready, 1'b0);
    check_eq("wr_paddr", PADDR, 32'h10);
    check_eq("wr_pstrb", PSTRB, 4'hF);
    check_eq("wr_pwrite", PWRITE, 1'b1);
    PREADY = 1'b1;
    step();
    check_eq("wr_access", {PSEL, PENABLE}, 2'b11);
    check_eq("wr_pwdata", PWDATA, 32'hA5A5_0001);
    check_eq("wr_no_rsp_yet", rsp_valid, 1'b0);
    step();
    PREADY = 1'b0;
    check_eq("wr_rsp_at_n3", rsp_valid, 1'b1);
    check_eq("wr_rsp_err", rsp_err, 1'b0);
    check_eq("wr_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("wr_psel_dropped", {PSEL, PENABLE}, 2'b00);
    consume();

    // Read with 3 wait states
    run_xfer(1'b0, 32'h20, 32'h1111_2222, 4'hF, 3, 32'hDEAD_BEEF, 1'b0,
             lat, acc, psel_cyc, stable, strb_obs);
    check_eq("rd_latency", lat, 6);
    check_eq("rd_psel_cycles", psel_cyc, 5);
    check_eq("rd_addr_stable", stable, 1'b1);
    check_eq("rd_pstrb_zero", strb_obs, 4'h0);
    check_eq("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("rd_err", rsp_err, 1'b0);
    check_eq("rd_pwdata_kept", PWDATA, 32'hA5A5_0001);
    consume();

    // Write with slave error, then a clean read
    run_xfer(1'b1, 32'h40, 32'h0BAD_0BAD, 4'h3, 1, 32'h0, 1'b1,
             lat, acc, psel_cyc, stable, strb_obs);
    check_eq("slverr_latency", lat, 4);
    check_eq("slverr_pstrb", strb_obs, 4'h3);
    check_eq("slverr_err", rsp_err, 1'b1);
    check_eq("slverr_timeout", rsp_timeout, 1'b0);
    consume();
    run_xfer(1'b0, 32'h44, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0,
             lat, acc, psel_cyc, stable, strb_obs);
    check_eq("after_err_rdata", rsp_rdata, 32'hCAFE_F00D);
    check_eq("after_err_err", rsp_err, 1'b0);
    consume();

    // Hung slave: watchdog abort after 16 ACCESS cycles
    run_xfer(1'b0, 32'h30, 32'h0, 4'h0, 1000, 32'h1234_5678, 1'b0,
             lat, acc, psel_cyc, stable, strb_obs);
    check_eq("to_access_cycles", acc, 16);
    check_eq("to_err", rsp_err, 1'b1);
    check_eq("to_timeout", rsp_timeout, 1'b1);
    check_eq("to_rdata", rsp_rdata, 32'h0);
    check_eq("to_psel", PSEL, 1'b0);

    // Response back-pressure with a waiting command: held 5 cycles, nothing accepted
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h5555_AAAA;
    cmd_strb = 4'hC;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_rsp_valid", rsp_valid, 1'b1);
      check_eq("bp_rsp_fields", {rsp_err, rsp_timeout, rsp_rdata}, {2'b11, 32'h0});
      check_eq("bp_cmd_ready", cmd_ready, 1'b0);
      check_eq("bp_psel", PSEL, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_eq("bp_released_idle", {rsp_valid, cmd_ready, PSEL}, 3'b010);
    step();
    cmd_valid = 1'b0;
    check_eq("bp_accept_setup", {PSEL, PENABLE}, 2'b10);
    check_eq("bp_accept_addr", PADDR, 32'h50);

    // Reset mid-ACCESS drops the transfer
    step();
    check_eq("rst_in_access", {PSEL, PENABLE}, 2'b11);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    check_eq("rst_ctrl_zero", {PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid}, 5'b0);
    check_eq("rst_bus_zero", {PADDR, PWDATA, PSTRB}, 68'h0);
    step();
    check_eq("rst_no_rsp", rsp_valid, 1'b0);
    run_xfer(1'b0, 32'h60, 32'h0, 4'h0, 2, 32'h0F0F_A0A0, 1'b0,
             lat, acc, psel_cyc, stable, strb_obs);
    check_eq("rst_recover_lat", lat, 5);
    check_eq("rst_recover_rdata", rsp_rdata, 32'h0F0F_A0A0);
    consume();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
